mem_lsu: RTL

Parametrised load/store unit for the MEM stage of the RV core. It replaces the fixed three-cycle read-modify-write memory path with byte-enable stores, a configurable fixed-latency or ack-handshake RAM protocol, an access timeout, and misalignment/access-fault exception reporting. It sits between EXE and WB and drives the data RAM port, `stall_o` to pipectrl, and the registered writeback/forwarding outputs.

---
 rtl/mem_lsu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with byte-enable stores, fixed-latency or ack RAM protocol,
// access timeout and misalignment/access-fault reporting.
module mem_lsu #(
  parameter int XLEN        = 32,
  parameter int USE_ACK     = 0,
  parameter int WAIT_CYCLES = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_we_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [2:0]        opfunc3_i,
  input  logic [XLEN-1:0]   ram_rdata_i,
  input  logic              ram_ack_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [XLEN-1:0]   ram_addr_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  output logic [XLEN/8-1:0] ram_be_o,
  output logic              stall_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_we_o,
  output logic              exc_valid_o,
  output logic [3:0]        exc_cause_o,
  output logic [XLEN-1:0]   exc_tval_o
);
  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);
  localparam int CMAX = (USE_ACK != 0) ? TIMEOUT : WAIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            to_q, to_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_we_q, rd_we_d;
  logic            exc_valid_q, exc_valid_d;
  logic [3:0]      exc_cause_q, exc_cause_d;
  logic [XLEN-1:0] exc_tval_q, exc_tval_d;

  logic [OW-1:0]   off;
  logic [1:0]      sz;
  logic            acc, is_ld, legal, mis, go, en, upd, exc_to, exc;
  logic [NB-1:0]   mask;
  logic [XLEN-1:0] sh, ld_val;
  logic            unused_pc;

  assign unused_pc = ^pc_i;

  always_comb begin
    off    = mem_addr_i[OW-1:0];
    sz     = opfunc3_i[1:0];
    acc    = mem_re_i | mem_we_i;
    is_ld  = mem_re_i & ~mem_we_i;
    legal  = mem_we_i ? (~opfunc3_i[2] & (sz != 2'd3 || XLEN == 64))
                      : (opfunc3_i != 3'd7 && (XLEN == 64 || (opfunc3_i != 3'd3 && opfunc3_i != 3'd6)));
    mis    = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'd0) || (sz == 2'd3 && off != '0);
    go     = acc & legal & ~mis;
    // reset gates the combinational RAM side so an aborted access drops immediately
    en     = go & rst_ni;
    mask   = sz == 2'd0 ? NB'(1) : sz == 2'd1 ? NB'(3) : sz == 2'd2 ? NB'(15) : '1;
    ram_req_o   = en & (state_q == IDLE) & ~flush_i;
    stall_o     = en & (state_q != DONE);
    ram_we_o    = en & mem_we_i;
    ram_addr_o  = en ? {mem_addr_i[XLEN-1:OW], OW'(0)} : '0;
    ram_be_o    = (en & mem_we_i) ? mask << off : '0;
    ram_wdata_o = !(en & mem_we_i) ? '0
                : sz == 2'd0 ? {NB{rd_data_i[7:0]}}
                : sz == 2'd1 ? {(NB/2){rd_data_i[15:0]}}
                : sz == 2'd2 ? {(NB/4){rd_data_i[31:0]}} : rd_data_i;
    sh     = rdata_q >> {off, 3'b000};
    ld_val = sz == 2'd0 ? (opfunc3_i[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0])))
           : sz == 2'd1 ? (opfunc3_i[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0])))
           : sz == 2'd2 ? (opfunc3_i[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = WAIT;
        cnt_d   = CW'(CMAX - 1);
        to_d    = 1'b0;
      end
      WAIT: if ((USE_ACK != 0 && ram_ack_i) || cnt_q == '0) begin
        state_d = DONE;
        rdata_d = ram_rdata_i;
        to_d    = (USE_ACK != 0) && !ram_ack_i;
      end else cnt_d = cnt_q - 1'b1;
      default: if (!stall_i) state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    upd         = ~flush_i & ~stall_i & ~stall_o;
    exc_to      = (state_q == DONE) & to_q;
    exc         = (acc & legal & mis) | exc_to;
    rd_addr_d   = flush_i ? '0 : upd ? rd_addr_i : rd_addr_q;
    rd_data_d   = flush_i ? '0 : !upd ? rd_data_q
                : (go & is_ld & (state_q == DONE) & ~exc) ? ld_val : rd_data_i;
    rd_we_d     = ~flush_i & (upd ? rd_we_i & ~exc : rd_we_q);
    exc_valid_d = ~flush_i & (upd ? exc : exc_valid_q);
    exc_cause_d = flush_i ? '0 : upd ? (exc ? {2'b01, mem_we_i, exc_to} : 4'd0) : exc_cause_q;
    exc_tval_d  = flush_i ? '0 : upd ? (exc ? mem_addr_i : '0) : exc_tval_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      to_q        <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_we_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      to_q        <= to_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      rd_we_q     <= rd_we_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign rd_we_o     = rd_we_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_tval_o  = exc_tval_q;
endmodule
